// File: rtl/instruction_fetch_pkg.sv
// Shared RV32E fetch definitions: data widths, reset PC, the NOP encoding and the buffer entry layout.
package instruction_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // ADDI x0,x0,0 -- shown on the decode side whenever the buffer is empty
  localparam logic [XLEN-1:0] I_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_ORI     = 3'b110;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} pairs; slot 0 is always the head, flush beats push and pop.
module fetch_buffer
  import instruction_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  fetch_entry_t slot_reg [2];
  logic [1:0]   count_reg;
  logic         pop_eff;
  logic         push_eff;
  logic         wr_idx;

  assign pop_eff  = pop && (count_reg != 2'd0);
  assign push_eff = push && ((count_reg != 2'd2) || pop_eff);
  // Tail position once this cycle's pop has shifted slot 1 down
  assign wr_idx   = (count_reg == 2'd2) || ((count_reg == 2'd1) && !pop_eff);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        slot_reg[i] <= '0;
      end
    end else if (flush) begin
      count_reg <= 2'd0;
    end else begin
      count_reg <= count_reg - {1'b0, pop_eff} + {1'b0, push_eff};
      if (pop_eff) begin
        slot_reg[0] <= slot_reg[1];
      end
      if (push_eff) begin
        slot_reg[wr_idx] <= din;
      end
    end
  end

  assign dout  = slot_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/instruction_fetch.sv
// RV32E fetch stage: PC register, ROM addressing, redirect handling and the decode-side buffer.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_reg;
  logic            misaligned_reg;
  logic            pop;
  logic            push;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    fetched;

  // A redirect flushes the buffer, so any handshake in that cycle is void
  assign pop     = instr_valid && instr_ready && !redirect_valid;
  assign push    = fetch_en && !redirect_valid && ((count < 2'(BUF_DEPTH)) || pop);
  assign fetched = '{pc: pc_reg, word: rom_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      misaligned_reg <= 1'b0;
    end else begin
      misaligned_reg <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc_reg <= word_align(redirect_pc);
      end else if (push) begin
        pc_reg <= pc_reg + 32'd4;
      end
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fetched),
    .dout  (head),
    .count (count)
  );

  assign rom_addr    = pc_reg;
  assign instr_valid = (count != 2'd0);
  assign instr       = instr_valid ? head.word : I_NOP;
  assign instr_pc    = instr_valid ? head.pc : '0;
  assign misaligned  = misaligned_reg;

endmodule
